memif_rd_dma: RTL and testbench

//  Read-DMA sequencer acting as one downstream master of the memif bus (e.g. behind memif_arb).

---
 rtl/memif_rd_dma.sv | 197 +++++++++++++++++++
 tb/tb_memif_rd_dma.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/memif_rd_dma.sv
// memif_rd_dma: splits a (base, len) read job into memif bursts of up to BURST words and streams the data from a FIFO.
// Latency: first command 2 cycles after start; a returned word appears on o_data the cycle after its m_rstb.
// Backpressure: o_ready only stalls the FIFO; a burst issues only once FIFO space for it is free. Job looping: MEMIF_RD_DMA_LOOP_EN.
module memif_rd_dma #(
  parameter int AW        = 22,
  parameter int DW        = 32,
  parameter int BURST     = 64,
  parameter int FIFO_LOG2 = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] cfg_base,
  input  logic [15:0]   cfg_len,
  input  logic          cfg_loop,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] m_addr,
  output logic [6:0]    m_len,
  output logic          m_rw,
  output logic          m_valid,
  input  logic          m_ready,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_rstb,
  input  logic          m_rlast,
  output logic [DW-1:0] o_data,
  output logic          o_valid,
  input  logic          o_ready
);
  localparam int DEPTH = 1 << FIFO_LOG2;

  typedef enum logic [2:0] {IDLE, CHECK, CMD, DATA, FLUSH} state_t;
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [6:0]    len;
  } cmd_t;

  state_t        state_q, state_d;
  cmd_t          cmd_q, cmd_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   rem_q, rem_d;
  logic          done_q, done_d;
  logic          abort_q, abort_d;
`ifdef MEMIF_RD_DMA_LOOP_EN
  logic [AW-1:0] base_q, base_d;
  logic [15:0]   len_q, len_d;
`else
  logic          cfg_loop_unused;
  assign cfg_loop_unused = cfg_loop;
`endif

  logic [DW-1:0]        mem_q [DEPTH];
  logic [FIFO_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_LOG2:0]   cnt_q, cnt_d, fifo_free;
  logic                 fifo_flush, push, pop;
  logic [15:0]          burst_n;
  logic [7:0]           cmd_words;
  logic                 abort_any;

  assign burst_n   = (rem_q > 16'(BURST)) ? 16'(BURST) : rem_q;
  assign cmd_words = {1'b0, cmd_q.len} + 8'd1;
  assign fifo_free = (FIFO_LOG2+1)'(DEPTH) - cnt_q;
  assign abort_any = abort_q | abort;

  // The stream is blanked during FLUSH so nothing escapes in the clearing cycle.
  assign o_valid = (cnt_q != '0) && (state_q != FLUSH);
  assign o_data  = mem_q[rd_ptr_q];
  assign pop     = o_valid && o_ready;
  assign push    = m_rstb && (state_q == DATA) && ((cnt_q != (FIFO_LOG2+1)'(DEPTH)) || pop);

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign m_addr  = cmd_q.addr;
  assign m_len   = cmd_q.len;
  assign m_rw    = 1'b1;
  assign m_valid = (state_q == CMD);

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    done_d     = 1'b0;
    abort_d    = abort_q | (abort && (state_q != IDLE));
    fifo_flush = 1'b0;
`ifdef MEMIF_RD_DMA_LOOP_EN
    base_d     = base_q;
    len_d      = len_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = cfg_base;
          rem_d   = cfg_len;
          state_d = CHECK;
`ifdef MEMIF_RD_DMA_LOOP_EN
          base_d  = cfg_base;
          len_d   = cfg_len;
`endif
        end
      end
      CHECK: begin
        if (abort_any) begin
          state_d = FLUSH;
        end else if (rem_q == 16'd0) begin
          done_d = 1'b1;
`ifdef MEMIF_RD_DMA_LOOP_EN
          if (cfg_loop) begin
            addr_d = base_q;
            rem_d  = len_q;
          end else begin
            state_d = IDLE;
            abort_d = 1'b0;
          end
`else
          state_d = IDLE;
          abort_d = 1'b0;
`endif
        end else if (32'(fifo_free) >= 32'(burst_n)) begin
          cmd_d.addr = addr_q;
          cmd_d.len  = 7'(burst_n - 16'd1);
          state_d    = CMD;
        end
      end
      CMD: begin
        // A posted command is never retracted, even on abort.
        if (m_ready) begin
          addr_d  = addr_q + AW'(cmd_words);
          rem_d   = rem_q - 16'(cmd_words);
          state_d = DATA;
        end
      end
      DATA: begin
        if (m_rstb && m_rlast) state_d = abort_any ? FLUSH : CHECK;
      end
      FLUSH: begin
        fifo_flush = 1'b1;
        done_d     = 1'b1;
        abort_d    = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (fifo_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      cnt_d = cnt_q + (FIFO_LOG2+1)'(push) - (FIFO_LOG2+1)'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cmd_q    <= '0;
      addr_q   <= '0;
      rem_q    <= '0;
      done_q   <= 1'b0;
      abort_q  <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
`ifdef MEMIF_RD_DMA_LOOP_EN
      base_q   <= '0;
      len_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      done_q   <= done_d;
      abort_q  <= abort_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
`ifdef MEMIF_RD_DMA_LOOP_EN
      base_q   <= base_d;
      len_q    <= len_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push && !fifo_flush) mem_q[wr_ptr_q] <= m_rdata;
  end
endmodule

// File: tb/tb_memif_rd_dma.sv
// tb_memif_rd_dma: directed bench for memif_rd_dma with a memif read responder returning {10'h2A5, addr} per word.
// Runs with FIFO_LOG2=7 so the space-reservation hold is reachable with the default 64-word burst.
module tb_memif_rd_dma;
  logic        clk, rst_n;
  logic [21:0] cfg_base;
  logic [15:0] cfg_len;
  logic        cfg_loop, start, abort;
  logic        busy, done;
  logic [21:0] m_addr;
  logic [6:0]  m_len;
  logic        m_rw, m_valid, m_ready;
  logic [31:0] m_rdata;
  logic        m_rstb, m_rlast;
  logic [31:0] o_data;
  logic        o_valid, o_ready;

  logic        ready_en;
  logic [21:0] cmd_a[$];
  logic [6:0]  cmd_l[$];
  logic [31:0] got[$];
  int          done_cnt;
  int          vectors, miscompares;

  memif_rd_dma #(.AW(22), .DW(32), .BURST(64), .FIFO_LOG2(7)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_base(cfg_base), .cfg_len(cfg_len), .cfg_loop(cfg_loop),
    .start(start), .abort(abort), .busy(busy), .done(done),
    .m_addr(m_addr), .m_len(m_len), .m_rw(m_rw), .m_valid(m_valid), .m_ready(m_ready),
    .m_rdata(m_rdata), .m_rstb(m_rstb), .m_rlast(m_rlast),
    .o_data(o_data), .o_valid(o_valid), .o_ready(o_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // memif responder and output monitors: sample on negedge, drive just after posedge
  initial begin : slave
    int          beats;
    logic [21:0] raddr, ca;
    logic [6:0]  cl;
    logic        acc;
    beats = 0; raddr = '0;
    m_ready = 1'b0; m_rstb = 1'b0; m_rlast = 1'b0; m_rdata = '0;
    forever begin
      @(negedge clk);
      acc = m_valid && m_ready;
      ca  = m_addr;
      cl  = m_len;
      if (done) done_cnt++;
      if (o_valid && o_ready) got.push_back(o_data);
      @(posedge clk); #1;
      if (acc) begin
        cmd_a.push_back(ca);
        cmd_l.push_back(cl);
        beats = int'(cl) + 1;
        raddr = ca;
      end
      m_ready = ready_en;
      if (beats > 0) begin
        m_rstb  = 1'b1;
        m_rlast = (beats == 1);
        m_rdata = {10'h2A5, raddr};
        raddr   = raddr + 22'd1;
        beats--;
      end else begin
        m_rstb  = 1'b0;
        m_rlast = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic go(input logic [21:0] b, input logic [15:0] l);
    @(posedge clk); #1;
    cfg_base = b; cfg_len = l; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int target, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (done_cnt >= target) break;
      @(posedge clk); #1;
    end
    chk(tag, 64'(done_cnt >= target), 64'd1);
  endtask

  task automatic clear_log();
    cmd_a.delete(); cmd_l.delete(); got.delete(); done_cnt = 0;
  endtask

  function automatic int count_bad(input logic [21:0] base);
    int bad = 0;
    logic [21:0] a;
    for (int i = 0; i < got.size(); i++) begin
      a = base + 22'(i);
      if (got[i] !== {10'h2A5, a}) bad++;
    end
    return bad;
  endfunction

  initial begin
    vectors = 0; miscompares = 0; done_cnt = 0;
    rst_n = 1'b1; start = 1'b0; abort = 1'b0; cfg_loop = 1'b0;
    cfg_base = '0; cfg_len = '0; o_ready = 1'b0; ready_en = 1'b1;
    #3 rst_n = 1'b0;
    #9;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mvalid", m_valid, 0);
    chk("rst_maddr", m_addr, 0);
    chk("rst_mlen", m_len, 0);
    chk("rst_mrw", m_rw, 1);
    chk("rst_ovalid", o_valid, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 clear_log();

    // 1: 200 words from 0x100, stream always ready
    o_ready = 1'b1;
    go(22'h000100, 16'd200);
    wait_done("t1_done_seen", 1, 2000);
    repeat (20) @(posedge clk);
    #1;
    chk("t1_ncmd", cmd_a.size(), 4);
    chk("t1_cmd0", {cmd_a[0], 1'b0, cmd_l[0]}, {22'h000100, 8'd63});
    chk("t1_cmd1", {cmd_a[1], 1'b0, cmd_l[1]}, {22'h000140, 8'd63});
    chk("t1_cmd2", {cmd_a[2], 1'b0, cmd_l[2]}, {22'h000180, 8'd63});
    chk("t1_cmd3", {cmd_a[3], 1'b0, cmd_l[3]}, {22'h0001C0, 8'd7});
    chk("t1_nwords", got.size(), 200);
    chk("t1_bad_words", count_bad(22'h000100), 0);
    chk("t1_ndone", done_cnt, 1);
    chk("t1_busy", busy, 0);
    clear_log();

    // 2: empty job
    go(22'h000777, 16'd0);
    chk("t2_busy_c1", busy, 1);
    chk("t2_done_c1", done, 0);
    @(posedge clk); #1;
    chk("t2_done_c2", done, 1);
    chk("t2_busy_c2", busy, 0);
    @(posedge clk); #1;
    chk("t2_done_c3", done, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("t2_ncmd", cmd_a.size(), 0);
    clear_log();

    // 3: stream stalled, 128-word FIFO, 300 words
    o_ready = 1'b0;
    go(22'h002000, 16'd300);
    repeat (200) @(posedge clk);
    #1;
    chk("t3_ncmd_full", cmd_a.size(), 2);
    chk("t3_mvalid_held", m_valid, 0);
    chk("t3_ovalid_full", o_valid, 1);
    chk("t3_busy_full", busy, 1);
    o_ready = 1'b1;
    repeat (63) @(posedge clk);
    #1 o_ready = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("t3_ncmd_63free", cmd_a.size(), 2);
    o_ready = 1'b1;
    @(posedge clk); #1;
    o_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("t3_ncmd_64free", cmd_a.size(), 3);
    chk("t3_cmd2", {cmd_a[2], 1'b0, cmd_l[2]}, {22'h002080, 8'd63});
    o_ready = 1'b1;
    wait_done("t3_done_seen", 1, 1500);
    repeat (200) @(posedge clk);
    #1;
    chk("t3_ncmd", cmd_a.size(), 5);
    chk("t3_cmd4", {cmd_a[4], 1'b0, cmd_l[4]}, {22'h002100, 8'd43});
    chk("t3_nwords", got.size(), 300);
    chk("t3_bad_words", count_bad(22'h002000), 0);
    chk("t3_ndone", done_cnt, 1);
    clear_log();

    // 4: address wrap at 2^22
    go(22'h3FFFF0, 16'd96);
    wait_done("t4_done_seen", 1, 1000);
    repeat (20) @(posedge clk);
    #1;
    chk("t4_ncmd", cmd_a.size(), 2);
    chk("t4_cmd0", {cmd_a[0], 1'b0, cmd_l[0]}, {22'h3FFFF0, 8'd63});
    chk("t4_cmd1", {cmd_a[1], 1'b0, cmd_l[1]}, {22'h000030, 8'd31});
    chk("t4_nwords", got.size(), 96);
    chk("t4_bad_words", count_bad(22'h3FFFF0), 0);
    clear_log();

    // 5: abort while the command is stalled
    o_ready = 1'b0; ready_en = 1'b0;
    repeat (2) @(posedge clk);
    go(22'h000500, 16'd100);
    for (int k = 0; k < 20; k++) begin
      if (m_valid) break;
      @(posedge clk); #1;
    end
    chk("t5_mvalid_up", m_valid, 1);
    repeat (3) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("t5_mvalid_kept", m_valid, 1);
    chk("t5_busy_kept", busy, 1);
    ready_en = 1'b1;
    wait_done("t5_done_seen", 1, 300);
    repeat (10) @(posedge clk);
    #1;
    chk("t5_ovalid", o_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_ndone", done_cnt, 1);
    chk("t5_ncmd", cmd_a.size(), 1);
    chk("t5_cmd0", {cmd_a[0], 1'b0, cmd_l[0]}, {22'h000500, 8'd63});
    chk("t5_nwords", got.size(), 0);
    clear_log();

    // 6: loop request
    o_ready = 1'b1; cfg_loop = 1'b1;
    go(22'h000040, 16'd10);
`ifdef MEMIF_RD_DMA_LOOP_EN
    wait_done("t6_three_passes", 3, 400);
    cfg_loop = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (!busy) break;
      @(posedge clk); #1;
    end
    repeat (10) @(posedge clk);
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_ncmd_eq_ndone", cmd_a.size(), done_cnt);
    chk("t6_nwords", got.size(), 10 * done_cnt);
`else
    wait_done("t6_done_seen", 1, 200);
    repeat (40) @(posedge clk);
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_ndone", done_cnt, 1);
    chk("t6_ncmd", cmd_a.size(), 1);
    chk("t6_nwords", got.size(), 10);
`endif
    chk("t6_cmd0", {cmd_a[0], 1'b0, cmd_l[0]}, {22'h000040, 8'd9});
    cfg_loop = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
